// File: rtl/alu_ctrl_pkg.sv
// Shared opcode, flag-index and FSM-state definitions for the ALU arbiter slice.
package alu_ctrl_pkg;

    localparam logic [3:0] OpAdd = 4'b0000;
    localparam logic [3:0] OpSub = 4'b0001;
    localparam logic [3:0] OpAnd = 4'b0010;
    localparam logic [3:0] OpOr  = 4'b0011;
    localparam logic [3:0] OpShl = 4'b0100;
    localparam logic [3:0] OpShr = 4'b0101;
    localparam logic [3:0] OpXor = 4'b0110;

    localparam int unsigned FlagCarry = 3;
    localparam int unsigned FlagSign  = 2;
    localparam int unsigned FlagZero  = 1;
    localparam int unsigned FlagShout = 0;

    typedef enum logic [1:0] {
        StIdle = 2'b00,
        StExec = 2'b01,
        StResp = 2'b10
    } state_e;

    function automatic logic op_legal(input logic [3:0] op);
        return op <= OpXor;
    endfunction

endpackage

// File: rtl/alu.sv
// Combinational 8-bit ALU; outputs are forced to zero while alu_enable is low.
module alu
    import alu_ctrl_pkg::*;
(
    input  logic       alu_enable,
    input  logic [7:0] a,
    input  logic [7:0] b,
    input  logic [3:0] opcode,
    output logic [7:0] out,
    output logic [3:0] flag_out
);

    logic [8:0] sum9;
    logic [8:0] sh9;
    logic       carry;
    logic       shout;

    always_comb begin
        out   = '0;
        carry = 1'b0;
        shout = 1'b0;
        sum9  = '0;
        sh9   = '0;
        if (alu_enable) begin
            case (opcode)
                OpAdd: begin
                    sum9  = {1'b0, a} + {1'b0, b};
                    out   = sum9[7:0];
                    carry = sum9[8];
                end
                OpSub: begin
                    // Bit 8 of the 9-bit difference is the borrow.
                    sum9  = {1'b0, a} - {1'b0, b};
                    out   = sum9[7:0];
                    carry = sum9[8];
                end
                OpAnd: out = a & b;
                OpOr:  out = a | b;
                OpXor: out = a ^ b;
                OpShl: begin
                    sh9   = {1'b0, a} << b[2:0];
                    out   = sh9[7:0];
                    shout = sh9[8];
                end
                OpShr: begin
                    sh9   = {a, 1'b0} >> b[2:0];
                    out   = sh9[8:1];
                    shout = sh9[0];
                end
                default: out = '0;
            endcase
        end
    end

    always_comb begin
        flag_out            = '0;
        flag_out[FlagCarry] = carry;
        flag_out[FlagSign]  = alu_enable & out[7];
        flag_out[FlagZero]  = alu_enable & (out == 8'h00);
        flag_out[FlagShout] = shout;
    end

endmodule

// File: rtl/alu_arbiter.sv
// Two-requester round-robin front end that serialises operations onto one shared ALU.
module alu_arbiter
    import alu_ctrl_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] req_valid,
    output logic [1:0] req_ready,
    input  logic [7:0] req0_a,
    input  logic [7:0] req0_b,
    input  logic [7:0] req1_a,
    input  logic [7:0] req1_b,
    input  logic [3:0] req0_op,
    input  logic [3:0] req1_op,
    output logic [1:0] rsp_valid,
    input  logic [1:0] rsp_ready,
    output logic [7:0] rsp_data,
    output logic [3:0] rsp_flags,
    output logic       rsp_err,
    output logic [3:0] flags_q,
    output logic       busy
);

    state_e     state_q, state_d;
    logic       last_grant_q;
    logic       grant_q, grant_d;
    logic [7:0] a_q, b_q;
    logic [3:0] op_q;
    logic [7:0] rsp_data_q;
    logic [3:0] rsp_flags_q;
    logic       rsp_err_q;
    logic [3:0] last_flags_q;

    logic       accept;
    logic       consume;
    logic       legal;
    logic       alu_enable;
    logic [1:0] grant_vec;
    logic [7:0] alu_out;
    logic [3:0] alu_flags;

    alu u_alu (
        .alu_enable (alu_enable),
        .a          (a_q),
        .b          (b_q),
        .opcode     (op_q),
        .out        (alu_out),
        .flag_out   (alu_flags)
    );

    always_comb begin
        state_d    = state_q;
        grant_d    = grant_q;
        accept     = 1'b0;
        consume    = 1'b0;
        alu_enable = 1'b0;
        grant_vec  = 2'b00;
        rsp_valid  = 2'b00;
        legal      = op_legal(op_q);
        unique case (state_q)
            StIdle: begin
                if (|req_valid) begin
                    accept             = 1'b1;
                    // On a tie the requester that did not win last time goes first.
                    grant_d            = (req_valid == 2'b11) ? ~last_grant_q : req_valid[1];
                    grant_vec[grant_d] = 1'b1;
                    state_d            = StExec;
                end
            end
            StExec: begin
                alu_enable = legal;
                state_d    = StResp;
            end
            StResp: begin
                rsp_valid[grant_q] = 1'b1;
                if (rsp_ready[grant_q]) begin
                    consume = 1'b1;
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= StIdle;
            last_grant_q <= 1'b1;
            grant_q      <= 1'b0;
            a_q          <= '0;
            b_q          <= '0;
            op_q         <= '0;
            rsp_data_q   <= '0;
            rsp_flags_q  <= '0;
            rsp_err_q    <= 1'b0;
            last_flags_q <= '0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            if (accept) begin
                a_q  <= grant_d ? req1_a  : req0_a;
                b_q  <= grant_d ? req1_b  : req0_b;
                op_q <= grant_d ? req1_op : req0_op;
            end
            if (state_q == StExec) begin
                if (legal) begin
                    rsp_data_q   <= alu_out;
                    rsp_flags_q  <= alu_flags;
                    rsp_err_q    <= 1'b0;
                    last_flags_q <= alu_flags;
                end else begin
                    rsp_data_q  <= '0;
                    rsp_flags_q <= '0;
                    rsp_err_q   <= 1'b1;
                end
            end
            if (consume) begin
                last_grant_q <= grant_q;
            end
        end
    end

    // Gated by rst_n so a pending request cannot show ready while reset is held.
    assign req_ready = rst_n ? grant_vec : 2'b00;
    assign rsp_data  = rsp_data_q;
    assign rsp_flags = rsp_flags_q;
    assign rsp_err   = rsp_err_q;
    assign flags_q   = last_flags_q;
    assign busy      = (state_q != StIdle);

endmodule

// File: doc/alu_arbiter.md
ALU_ARBITER -- requirements
Module: alu_arbiter

Interface
REQ-001 SHALL have port clk, input, 1: the single clock; all state updates on its rising edge.
REQ-002 SHALL have port rst_n, input, 1: reset, asynchronous, active-low.
REQ-003 SHALL have port req_valid, input, 2: bit i means requester i presents an operation.
REQ-004 SHALL have port req_ready, output, 2: bit i means requester i's operation is accepted this cycle.
REQ-005 SHALL have ports req0_a, req0_b, req1_a, req1_b, input, 8 each: operands per requester.
REQ-006 SHALL have ports req0_op, req1_op, input, 4 each: opcode per requester.
REQ-007 SHALL have port rsp_valid, output, 2: bit i means a result is held for requester i.
REQ-008 SHALL have port rsp_ready, input, 2: bit i means requester i takes the result.
REQ-009 SHALL have port rsp_data, output, 8: registered result.
REQ-010 SHALL have port rsp_flags, output, 4: registered flags {carry, sign, zero, shift_out}, bits [3:0].
REQ-011 SHALL have port rsp_err, output, 1: the held response came from an illegal opcode.
REQ-012 SHALL have port flags_q, output, 4: flags of the last legal operation completed.
REQ-013 SHALL have port busy, output, 1: high whenever state is not IDLE.

Function
REQ-014 SHALL have a three-state FSM with states IDLE, EXEC and RESP; reset state is IDLE.
REQ-015 IDLE, some req_valid high: grant one requester, capture its a, b and op, assert its req_ready combinationally in that cycle, and go to EXEC.
REQ-016 Arbitration SHALL be round-robin:
- Only one requester valid: that requester is granted.
- Both valid: the requester not equal to last_grant is granted.
REQ-017 req_ready SHALL be 2'b00 in EXEC and RESP, and never have more than one bit set.
REQ-018 EXEC, legal opcode (0000 to 0110): drive alu_enable=1 with the captured operands for exactly one cycle, register the ALU out into rsp_data and flag_out into rsp_flags, clear rsp_err, and load flags_q; then go to RESP.
REQ-019 EXEC, illegal opcode (0111 to 1111): keep alu_enable=0, set rsp_data=0x00, rsp_flags=0000 and rsp_err=1, leave flags_q unchanged, and go to RESP.
REQ-020 alu_enable SHALL be 0 in every state except EXEC.
REQ-021 RESP: hold rsp_valid[g]=1 with data, flags and err stable until rsp_ready[g]=1.
- On that cycle: go to IDLE, set last_grant<=g, drop rsp_valid on the next edge.
REQ-022 rsp_ready on the non-granted bit, or outside RESP, SHALL be ignored.
REQ-023 Deassertion of req_valid or changes to operands after acceptance SHALL NOT affect the operation in flight.
REQ-024 Latency: accepted at edge N, rsp_valid high after edge N+2; minimum 3 cycles per operation (rsp_ready held high).
REQ-025 A new request SHALL NOT be accepted in the same cycle the previous response is consumed.

Reset
REQ-026 rst_n low SHALL asynchronously force:
- state=IDLE and last_grant=1 (requester 0 wins the first tie);
- req_ready=00 and rsp_valid=00;
- rsp_data=0x00, rsp_flags=0000, rsp_err=0, flags_q=0000 and busy=0.
REQ-027 Reset during EXEC or RESP SHALL abandon the operation with no response delivered.

Structure
REQ-028 Shared package alu_ctrl_pkg SHALL hold:
- the opcode constants ADD=0000, SUB=0001, AND=0010, OR=0011, SHL=0100, SHR=0101, XOR=0110;
- the flag bit indices CARRY=3, SIGN=2, ZERO=1, SHOUT=0;
- the FSM state encoding.
REQ-029 SHALL instantiate the existing alu module as its single sub-module, ports alu_enable, a, b, opcode, out and flag_out; no other arithmetic logic.

Verification
REQ-030 Requester 0, ADD 0x7F+0x01, then ADD 0xFF+0x01 -> rsp_data 0x80 with flags 0100, then 0x00 with flags 1010; each rsp_valid appears two cycles after acceptance.
REQ-031 Requester 1, SUB 0x03-0x05 -> 0xFE with flags 1100; SUB 0x05-0x05 -> 0x00 with flags 0010.
REQ-032 SHL 0x81 by 1 -> 0x02 with flags 0001; SHR 0x03 by 1 -> 0x01 with flags 0001.
REQ-033 Both req_valid held continuously after reset -> grants alternate 0,1,0,1; rsp_ready delayed 3 cycles -> rsp_data stable and no new req_ready while waiting.
REQ-034 Opcode 1001 after ADD 0xFF+0x01 -> rsp_err=1, rsp_data 0x00, flags_q stays 1010, and alu_enable never asserted.
REQ-035 rst_n pulsed low during RESP -> all outputs reset immediately, no rsp_valid afterwards, next tie granted to requester 0.
